// File: rtl/button_event_decoder.sv
// button_event_decoder: turns debounced button levels into one-cycle command pulses
// with plus/minus auto-repeat and short/long discrimination on the program button.
module button_event_decoder #(
  parameter int HOLD_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter int LONG_CYCLES   = 2000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic debounced_plus_button,
  input  logic debounced_minus_button,
  input  logic debounced_program_button,
  input  logic debounced_set_alarm_button,
  input  logic debounced_turn_off_alarm_button,
  output logic plus_pulse,
  output logic minus_pulse,
  output logic program_short_pulse,
  output logic program_long_pulse,
  output logic set_alarm_pulse,
  output logic turn_off_alarm_pulse
);
  localparam int PM_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int PMW = $clog2(PM_MAX + 1);
  localparam int PW = $clog2(LONG_CYCLES + 1);
  // Counters compare against N-1 because the pulse is registered on the edge the count would reach N.
  localparam logic [PMW-1:0] HOLD_LAST = PMW'(HOLD_CYCLES - 1);
  localparam logic [PMW-1:0] REP_LAST = PMW'(REPEAT_CYCLES - 1);
  localparam logic [PW-1:0] LONG_LAST = PW'(LONG_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} pm_state_t;
  typedef enum logic [1:0] {P_IDLE, P_TIMING, P_WAIT_RELEASE} p_state_t;
  logic [4:0] btn, prev_q, rise;
  pm_state_t pm_state_q, pm_state_d;
  p_state_t p_state_q, p_state_d;
  logic [PMW-1:0] pm_cnt_q, pm_cnt_d;
  logic [PW-1:0] p_cnt_q, p_cnt_d;
  logic dir_q, dir_d;
  logic latched, other;
  logic plus_q, plus_d, minus_q, minus_d;
  logic short_q, short_d, long_q, long_d;
  logic set_q, off_q;
  assign btn = {debounced_turn_off_alarm_button, debounced_set_alarm_button,
                debounced_program_button, debounced_minus_button, debounced_plus_button};
  assign rise = btn & ~prev_q;
  assign latched = dir_q ? btn[1] : btn[0];
  assign other = dir_q ? btn[0] : btn[1];
  assign plus_pulse = plus_q;
  assign minus_pulse = minus_q;
  assign program_short_pulse = short_q;
  assign program_long_pulse = long_q;
  assign set_alarm_pulse = set_q;
  assign turn_off_alarm_pulse = off_q;
  always_comb begin
    pm_state_d = pm_state_q;
    pm_cnt_d = pm_cnt_q;
    dir_d = dir_q;
    plus_d = 1'b0;
    minus_d = 1'b0;
    case (pm_state_q)
      IDLE: begin
        if (rise[0] && !btn[1]) begin
          plus_d = 1'b1;
          dir_d = 1'b0;
          pm_cnt_d = '0;
          pm_state_d = HOLD;
        end else if (rise[1] && !btn[0]) begin
          minus_d = 1'b1;
          dir_d = 1'b1;
          pm_cnt_d = '0;
          pm_state_d = HOLD;
        end else if (rise[0] || rise[1]) begin
          pm_cnt_d = '0;
          pm_state_d = LOCK;
        end
      end
      HOLD, REPEAT: begin
        if (other) begin
          pm_cnt_d = '0;
          pm_state_d = LOCK;
        end else if (!latched) begin
          pm_cnt_d = '0;
          pm_state_d = IDLE;
        end else if (pm_cnt_q == ((pm_state_q == HOLD) ? HOLD_LAST : REP_LAST)) begin
          plus_d = !dir_q;
          minus_d = dir_q;
          pm_cnt_d = '0;
          pm_state_d = REPEAT;
        end else begin
          pm_cnt_d = pm_cnt_q + 1'b1;
        end
      end
      LOCK: begin
        if (!btn[0] && !btn[1]) begin
          pm_cnt_d = '0;
          pm_state_d = IDLE;
        end
      end
      default: pm_state_d = IDLE;
    endcase
  end
  always_comb begin
    p_state_d = p_state_q;
    p_cnt_d = p_cnt_q;
    short_d = 1'b0;
    long_d = 1'b0;
    case (p_state_q)
      P_IDLE: begin
        if (rise[2]) begin
          p_cnt_d = '0;
          p_state_d = P_TIMING;
        end
      end
      P_TIMING: begin
        if (!btn[2]) begin
          short_d = 1'b1;
          p_cnt_d = '0;
          p_state_d = P_IDLE;
        end else if (p_cnt_q == LONG_LAST) begin
          long_d = 1'b1;
          p_cnt_d = '0;
          p_state_d = P_WAIT_RELEASE;
        end else begin
          p_cnt_d = p_cnt_q + 1'b1;
        end
      end
      P_WAIT_RELEASE: begin
        if (!btn[2]) begin
          p_cnt_d = '0;
          p_state_d = P_IDLE;
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pm_state_q <= IDLE;
      p_state_q <= P_IDLE;
      pm_cnt_q <= '0;
      p_cnt_q <= '0;
      dir_q <= 1'b0;
      plus_q <= 1'b0;
      minus_q <= 1'b0;
      short_q <= 1'b0;
      long_q <= 1'b0;
      set_q <= 1'b0;
      off_q <= 1'b0;
    end else begin
      prev_q <= btn;
      pm_state_q <= pm_state_d;
      p_state_q <= p_state_d;
      pm_cnt_q <= pm_cnt_d;
      p_cnt_q <= p_cnt_d;
      dir_q <= dir_d;
      plus_q <= plus_d;
      minus_q <= minus_d;
      short_q <= short_d;
      long_q <= long_d;
      set_q <= rise[3];
      off_q <= rise[4];
    end
  end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed scenarios checked every cycle against a timing model,
// plus literal pulse-edge lists per scenario.
module tb_button_event_decoder;
  localparam int H = 8, R = 4, L = 10;
  logic clk = 0, rst_n = 0;
  logic p = 0, m = 0, g = 0, s = 0, o = 0;
  logic plus_pulse, minus_pulse, program_short_pulse, program_long_pulse;
  logic set_alarm_pulse, turn_off_alarm_pulse;
  int cyc = 0, base = 0, n_cmp = 0, n_bad = 0;
  int q_plus[$], q_minus[$], q_short[$], q_long[$], q_set[$], q_off[$], none[$];
  bit pp, pm, pg, ps, po, rp, rm, rg;
  bit act, dir, lck, ptim, pwait;
  int t, h;
  bit e_plus, e_minus, e_short, e_long, e_set, e_off;
  button_event_decoder #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .debounced_plus_button(p), .debounced_minus_button(m),
    .debounced_program_button(g), .debounced_set_alarm_button(s),
    .debounced_turn_off_alarm_button(o),
    .plus_pulse(plus_pulse), .minus_pulse(minus_pulse),
    .program_short_pulse(program_short_pulse), .program_long_pulse(program_long_pulse),
    .set_alarm_pulse(set_alarm_pulse), .turn_off_alarm_pulse(turn_off_alarm_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc - base, a, e);
    end
  endtask
  task automatic chk_log(string nm, input int got[$], input int exp[$]);
    n_cmp++;
    if (got.size() != exp.size()) begin
      n_bad++;
      $display("FAIL %s pulse count: got %0d expected %0d", nm, got.size(), exp.size());
    end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      n_cmp++;
      if (got[i] - base != exp[i]) begin
        n_bad++;
        $display("FAIL %s pulse #%0d: got edge %0d expected edge %0d", nm, i, got[i] - base, exp[i]);
      end
    end
  endtask
  // Model: pulses follow from elapsed time since the press, not from any state encoding.
  always @(posedge clk) begin
    cyc++;
    {e_plus, e_minus, e_short, e_long, e_set, e_off} = '0;
    if (!rst_n) begin
      {pp, pm, pg, ps, po} = '0;
      {act, lck, ptim, pwait} = '0;
    end else begin
      rp = p && !pp;
      rm = m && !pm;
      rg = g && !pg;
      e_set = s && !ps;
      e_off = o && !po;
      if (lck) begin
        if (!p && !m) lck = 0;
      end else if (act) begin
        if (dir ? p : m) begin act = 0; lck = 1; end
        else if (!(dir ? m : p)) act = 0;
        else begin
          t++;
          if (t == H || (t > H && (t - H) % R == 0)) begin
            if (dir) e_minus = 1; else e_plus = 1;
          end
        end
      end else if (rp || rm) begin
        if (rp && !m) begin act = 1; dir = 0; t = 0; e_plus = 1; end
        else if (rm && !p) begin act = 1; dir = 1; t = 0; e_minus = 1; end
        else lck = 1;
      end
      if (pwait) begin
        if (!g) pwait = 0;
      end else if (ptim) begin
        if (g) begin
          h++;
          if (h == L) begin e_long = 1; ptim = 0; pwait = 1; end
        end else begin
          e_short = 1;
          ptim = 0;
        end
      end else if (rg) begin
        ptim = 1;
        h = 0;
      end
      {pp, pm, pg, ps, po} = {p, m, g, s, o};
    end
    #1;
    chk("plus_pulse", plus_pulse, e_plus);
    chk("minus_pulse", minus_pulse, e_minus);
    chk("program_short_pulse", program_short_pulse, e_short);
    chk("program_long_pulse", program_long_pulse, e_long);
    chk("set_alarm_pulse", set_alarm_pulse, e_set);
    chk("turn_off_alarm_pulse", turn_off_alarm_pulse, e_off);
    if (plus_pulse) q_plus.push_back(cyc);
    if (minus_pulse) q_minus.push_back(cyc);
    if (program_short_pulse) q_short.push_back(cyc);
    if (program_long_pulse) q_long.push_back(cyc);
    if (set_alarm_pulse) q_set.push_back(cyc);
    if (turn_off_alarm_pulse) q_off.push_back(cyc);
  end
  task automatic start();
    @(negedge clk);
    base = cyc;
    q_plus.delete(); q_minus.delete(); q_short.delete();
    q_long.delete(); q_set.delete(); q_off.delete();
  endtask
  task automatic goto(int n);
    while (cyc < base + n - 1) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    start(); goto(21);
    chk_log("idle plus", q_plus, none);
    chk_log("idle minus", q_minus, none);
    chk_log("idle short", q_short, none);
    chk_log("idle long", q_long, none);
    chk_log("idle set", q_set, none);
    chk_log("idle off", q_off, none);
    start(); goto(5); p = 1; goto(31); p = 0; goto(40);
    chk_log("repeat plus", q_plus, '{5, 13, 17, 21, 25, 29});
    chk_log("repeat minus", q_minus, none);
    start(); goto(5); g = 1; goto(10); g = 0; goto(20); g = 1; goto(41); g = 0; goto(50);
    chk_log("program short", q_short, '{10});
    chk_log("program long", q_long, '{30});
    start(); goto(5); m = 1; goto(15); p = 1; goto(25); p = 0; m = 0; goto(30); p = 1; goto(33); p = 0; goto(40);
    chk_log("lock minus", q_minus, '{5, 13});
    chk_log("lock plus", q_plus, '{30});
    start(); goto(7); s = 1; o = 1; goto(57); s = 0; o = 0; goto(60);
    chk_log("set once", q_set, '{7});
    chk_log("off once", q_off, '{7});
    start(); goto(5); p = 1; goto(10); rst_n = 0; goto(12); rst_n = 1; goto(30); p = 0; goto(40);
    chk_log("reset plus", q_plus, '{5, 12, 20, 24, 28});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the five debounced button levels produced by the alarm clock's debouncer stage and converts them into single-cycle command events for the time-setting and alarm control logic. It provides:
- edge-detected press pulses;
- auto-repeat on held plus/minus;
- short/long press discrimination on the program button.

It sits between the debouncer top and the clock/alarm control FSM. Every output is registered.

## Interface
Parameters:
- HOLD_CYCLES, default 1000: cycles plus/minus must stay held after the press pulse before auto-repeat starts (must be >= 2)
- REPEAT_CYCLES, default 200: auto-repeat period in cycles (must be >= 2)
- LONG_CYCLES, default 2000: program hold time that qualifies as a long press (must be >= 2)

Ports:
- clk  input  1  system clock; one clock domain only
- rst_n  input  1  reset, asynchronous, active-low
- debounced_plus_button  input  1  debounced level, 1 = pressed
- debounced_minus_button  input  1  debounced level
- debounced_program_button  input  1  debounced level
- debounced_set_alarm_button  input  1  debounced level
- debounced_turn_off_alarm_button  input  1  debounced level
- plus_pulse  output  1  one-cycle increment event (press or repeat)
- minus_pulse  output  1  one-cycle decrement event (press or repeat)
- program_short_pulse  output  1  one-cycle event on release before LONG_CYCLES
- program_long_pulse  output  1  one-cycle event when hold reaches LONG_CYCLES
- set_alarm_pulse  output  1  one-cycle event on press
- turn_off_alarm_pulse  output  1  one-cycle event on press

## Operation
- **Previous-sample registers:** one per input, used for edge detection. Reset value is 0, so a button held through reset release counts as a new press.
- **set_alarm / turn_off_alarm:** pulse on each rising edge (sample 1, previous 0). No repeat.
- **Plus/minus:** share one FSM and one hold counter. Counter width is ceil(log2(max(HOLD_CYCLES, REPEAT_CYCLES)+1)). States:
  - IDLE: rising edge on exactly one of plus/minus emits that button's pulse, clears the counter, latches the direction, and goes to HOLD.
  - HOLD: counter increments each cycle the latched button stays high. When the counter reaches HOLD_CYCLES, emit a pulse, clear the counter, and go to REPEAT.
  - REPEAT: each time the counter reaches REPEAT_CYCLES, emit a pulse and clear the counter.
  - HOLD/REPEAT exit: latched button sampled low returns to IDLE with no pulse. Other button sampled high goes to LOCK with no pulse.
  - LOCK: no plus/minus pulses. Returns to IDLE only when both buttons are sampled low.
  - IDLE with both rising in the same cycle, or one rising while the other is already high: no pulse, go to LOCK.
- **Program button:** separate FSM (P_IDLE, P_TIMING, P_WAIT_RELEASE) with its own counter, width ceil(log2(LONG_CYCLES+1)).
  - P_IDLE: rising edge clears the counter and goes to P_TIMING.
  - P_TIMING: counter increments while high. Reaching LONG_CYCLES emits program_long_pulse and goes to P_WAIT_RELEASE. Sampled low first emits program_short_pulse and goes to P_IDLE.
  - P_WAIT_RELEASE: no pulses. Sampled low returns to P_IDLE.
- **Independence:** the program, set_alarm and turn_off_alarm paths run independently of each other and of the plus/minus FSM. Simultaneous events on different outputs are all emitted in the same cycle.
- **Counters:** never wrap. They are cleared on every state transition and on every emitted repeat.

## Timing
- Reset (asynchronous assert): all pulse outputs 0, both FSMs idle, counters 0, previous-sample registers 0. Release is synchronous to clk.
- Press latency: input first sampled high at edge k gives a pulse high from edge k to edge k+1. Every pulse is exactly one cycle wide.
- Plus/minus held continuously from edge k gives pulses at edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, k+HOLD_CYCLES+2·REPEAT_CYCLES, and so on.
- Program first high at edge k:
  - still high at edge k+LONG_CYCLES: long pulse at that edge;
  - first sampled low at edge k+m, 1 <= m < LONG_CYCLES: short pulse at edge k+m.
  - A release after the long pulse emits nothing.
- Reset mid-hold: all in-flight timing is discarded. A button still high after reset release restarts as a fresh press.

## Test plan
All scenarios use HOLD_CYCLES=8, REPEAT_CYCLES=4, LONG_CYCLES=10.
- Reset with all inputs low, then idle 20 cycles -> all outputs 0 throughout.
- Plus held from edge 5 to edge 30 -> plus_pulse exactly at edges 5, 13, 17, 21, 25, 29; minus_pulse never.
- Program high for edges 5..9 (low at 10) -> program_short_pulse at edge 10 only. Program high for edges 20..40 -> program_long_pulse at edge 30 only, no short pulse on release.
- Minus held from edge 5; plus rises at edge 15 while minus is still held -> minus_pulse at 5 and 13 only. After both are released and plus is pressed alone, plus_pulse fires on its first sampled-high edge.
- set_alarm and turn_off_alarm rise together at edge 7 and are held for 50 cycles -> each pulses once at edge 7.
- Plus held from edge 5; rst_n low at edge 10, released at edge 12 while plus is still high -> outputs 0 during reset; plus_pulse at the first post-reset sample, with repeats restarting from that edge.
